// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared types, default sizes and helper functions for the
// convolution coprocessor register-bank controller.
//   state_t     : controller FSM encoding
//   onehot()    : one-hot decode of a register index
//   range_mask(): bit mask with bits lo..hi-1 set
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REGS   = 32;

  // Helpers work on the largest legal bank; callers slice to NUM_REGS.
  localparam int MAX_REGS = 32;
  localparam int IDX_W    = 6;

  function automatic logic [MAX_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Bits i with lo <= i < hi are set; empty when lo >= hi.
  function automatic logic [MAX_REGS-1:0] range_mask(input logic [IDX_W-1:0] lo,
                                                     input logic [IDX_W-1:0] hi);
    range_mask = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      range_mask[i] = (IDX_W'(i) >= lo) && (IDX_W'(i) < hi);
    end
  endfunction

endpackage

// File: rtl/conv_reg_bank.sv
// conv_reg_bank: bank of NUM_REGS sample registers, each with an
// enable-over-clear write port. Used for integration alongside the
// controller; the controller itself does not instantiate it.
// Ports:
//   clk : clock
//   en  : per-register write enable (has priority over clr)
//   clr : per-register synchronous clear
//   d   : shared write data
//   q   : flattened register contents, register i at q[i*DATA_WIDTH +: DATA_WIDTH]
module conv_reg_bank
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                           clk,
  input  logic [NUM_REGS-1:0]            en,
  input  logic [NUM_REGS-1:0]            clr,
  input  logic [DATA_WIDTH-1:0]          d,
  output logic [NUM_REGS*DATA_WIDTH-1:0] q
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] r;

    always_ff @(posedge clk) begin
      if (en[i]) begin
        r <= d;
      end else if (clr[i]) begin
        r <= '0;
      end
    end

    assign q[i*DATA_WIDTH +: DATA_WIDTH] = r;
  end

endmodule

// File: rtl/conv_reg_bank_ctrl.sv
// conv_reg_bank_ctrl: load/clear sequencer for the convolution coprocessor
// sample register bank. Clears the bank at frame start, then writes each
// accepted stream sample into the next register and pulses done_o.
// Optional feature macro: CONV_CTRL_ZERO_PAD_EN (early frame end on s_last_i,
// with a PAD cycle that clears the unused tail of the frame).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start_i, abort_i    : frame start (IDLE only) / frame cancel
//   len_i               : samples per frame (0 or > NUM_REGS means NUM_REGS)
//   s_valid_i, s_data_i, s_last_i, s_ready_o : sample stream handshake
//   en_o, clr_o, d_o    : registered register-bank write controls
//   busy_o, done_o      : status; done_o is a one-cycle completion pulse
//   count_o             : samples written in the current/last frame
module conv_reg_bank_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int CNT_W      = $clog2(NUM_REGS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      len_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic [NUM_REGS-1:0]   en_o,
  output logic [NUM_REGS-1:0]   clr_o,
  output logic [DATA_WIDTH-1:0] d_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam logic [CNT_W-1:0] NREGS_C = CNT_W'(NUM_REGS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      count_inc;
  logic [NUM_REGS-1:0]   en_d, clr_d;
  logic                  done_d;
  logic                  ld_data;
  logic                  accept;
  logic [MAX_REGS-1:0]   oh_full;

`ifdef CONV_CTRL_ZERO_PAD_EN
  logic [MAX_REGS-1:0]   pad_full;
`else
  logic                  unused_last;
  assign unused_last = s_last_i;
`endif

  assign s_ready_o = (state_q == LOAD);
  assign busy_o    = (state_q != IDLE);
  assign count_o   = count_q;
  assign accept    = s_valid_i && s_ready_o;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_idx_d = wr_idx_q;
    count_d  = count_q;
    en_d     = '0;
    clr_d    = '0;
    ld_data  = 1'b0;
    oh_full  = onehot(IDX_W'(wr_idx_q));
`ifdef CONV_CTRL_ZERO_PAD_EN
    pad_full = range_mask(IDX_W'(count_inc), IDX_W'(len_q));
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d    = ((len_i == '0) || (len_i > NREGS_C)) ? NREGS_C : len_i;
          wr_idx_d = '0;
          count_d  = '0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        clr_d   = '1;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          en_d     = oh_full[NUM_REGS-1:0];
          ld_data  = 1'b1;
          wr_idx_d = wr_idx_q + CNT_W'(1);
          count_d  = count_inc;
          if (count_inc == len_q) begin
            state_d = DONE;
`ifdef CONV_CTRL_ZERO_PAD_EN
          end else if (s_last_i) begin
            // Tail registers count+1..len_q-1 are cleared during PAD; the
            // sample being written is below that range, so no overlap with en.
            clr_d   = pad_full[NUM_REGS-1:0];
            state_d = PAD;
`endif
          end
        end
      end
      PAD:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything in the frame, including a same-cycle sample.
    if (abort_i && (state_q != IDLE)) begin
      state_d  = IDLE;
      en_d     = '0;
      clr_d    = '0;
      ld_data  = 1'b0;
      wr_idx_d = wr_idx_q;
      count_d  = count_q;
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_idx_q <= '0;
      count_q  <= '0;
      en_o     <= '0;
      clr_o    <= '0;
      d_o      <= '0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
      en_o     <= en_d;
      clr_o    <= clr_d;
      done_o   <= done_d;
      if (ld_data) begin
        d_o <= s_data_i;
      end
    end
  end

endmodule

// File: tb/tb_conv_reg_bank_ctrl.sv
module tb_conv_reg_bank_ctrl;

  localparam int DW = 8;
  localparam int NR = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic [NR-1:0] en;
  logic [NR-1:0] clr;
  logic [DW-1:0] d;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic [NR*DW-1:0] bank_q;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int clr_full_cnt = 0;
  logic prev_acc = 1'b0;

  logic [NR+DW-1:0] exp_q[$];
  logic [DW-1:0]    bank_mdl [NR];
  int               mdl_idx = 0;

  always #5 clk = ~clk;

  conv_reg_bank_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .len_i(len),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
    .s_ready_o(s_ready), .en_o(en), .clr_o(clr), .d_o(d),
    .busy_o(busy), .done_o(done), .count_o(count)
  );

  conv_reg_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bank (
    .clk(clk), .en(en), .clr(clr), .d(d), .q(bank_q)
  );

  // Scoreboard monitor: every enable must follow an accept and match the
  // expected {enable, data} pushed when that sample was handed over.
  always @(negedge clk) begin
    logic [NR+DW-1:0] e;
    if (en != '0) begin
      en_cnt++;
      checks++;
      if (!prev_acc) begin
        errors++;
        $display("FAIL en_without_accept en=%h", en);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en en=%h d=%h", en, d);
      end else begin
        e = exp_q.pop_front();
        if ({en, d} !== e) begin
          errors++;
          $display("FAIL en_data got en=%h d=%h exp en=%h d=%h", en, d, e[NR+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if ((en | clr) != '0) begin
      checks++;
      if ((en & clr) != '0) begin
        errors++;
        $display("FAIL exclusive en=%h clr=%h", en, clr);
      end
    end
    if (clr === '1) clr_full_cnt++;
    if (done === 1'b1) done_cnt++;
    prev_acc = (s_valid === 1'b1) && (s_ready === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic do_start(input logic [CW-1:0] l);
    start = 1'b1; len = l; mdl_idx = 0;
    for (int i = 0; i < NR; i++) bank_mdl[i] = '0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0 || clr !== '0) begin
      errors++;
      $display("FAIL clear_state busy=%b rdy=%b clr=%h exp 1 0 0", busy, s_ready, clr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (clr !== '1 || s_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL clear_out clr=%h rdy=%b cnt=%0d exp ffffffff 1 0", clr, s_ready, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] dat, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = dat; s_last = last;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout rdy=%b exp 1", s_ready);
    end else begin
      exp_q.push_back({NR'(32'h1 << mdl_idx), dat});
      bank_mdl[mdl_idx] = dat;
      mdl_idx++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b exp 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_last(input string tag, input logic [NR-1:0] exp_en);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done got=%b exp=1", tag, done);
    end
    checks++;
    if (en !== exp_en) begin
      errors++;
      $display("FAIL %s last_en got=%h exp=%h", tag, en, exp_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input int exp_cnt, input int d_done, input int d_clr);
    checks++;
    if (count !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL %s count got=%0d exp=%0d", tag, count, exp_cnt);
    end
    checks++;
    if (d_done !== 1) begin
      errors++;
      $display("FAIL %s done_pulses got=%0d exp=1", tag, d_done);
    end
    checks++;
    if (d_clr !== 1) begin
      errors++;
      $display("FAIL %s clear_cycles got=%0d exp=1", tag, d_clr);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s pending_enables got=%0d exp=0", tag, exp_q.size());
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (bank_q[i*DW +: DW] !== bank_mdl[i]) begin
        errors++;
        $display("FAIL %s bank[%0d] got=%h exp=%h", tag, i, bank_q[i*DW +: DW], bank_mdl[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; len = '0; s_valid = 0; s_data = '0; s_last = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({en, clr, d, done, count, busy, s_ready} !== '0) begin
      errors++;
      $display("FAIL reset en=%h clr=%h d=%h done=%b cnt=%0d busy=%b rdy=%b exp all 0",
               en, clr, d, done, count, busy, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int d0 = done_cnt, c0 = clr_full_cnt;
    logic [DW-1:0] v[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_start(4);
    for (int i = 0; i < 4; i++) send(v[i], 1'b0);
    check_last("basic", 32'h8);
    wait_idle();
    check_frame("basic", 4, done_cnt - d0, clr_full_cnt - c0);
    check_bank("basic");
  endtask

  task automatic test_valid_toggle();
    int d0 = done_cnt, c0 = clr_full_cnt, e0 = en_cnt;
    do_start(32);
    for (int i = 0; i < 32; i++) begin
      send(DW'(i * 7 + 3), 1'b0);
      if (i != 31) begin
        @(posedge clk); #1;
      end
    end
    check_last("toggle", 32'h8000_0000);
    wait_idle();
    check_frame("toggle", 32, done_cnt - d0, clr_full_cnt - c0);
    checks++;
    if (en_cnt - e0 !== 32) begin
      errors++;
      $display("FAIL toggle enables got=%0d exp=32", en_cnt - e0);
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    do_start(8);
    send(8'h5A, 1'b0);
    send(8'h6B, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, s_ready, done, en, clr} !== '0) begin
      errors++;
      $display("FAIL abort busy=%b rdy=%b done=%b en=%h clr=%h exp all 0", busy, s_ready, done, en, clr);
    end
    checks++;
    if (count !== CW'(2)) begin
      errors++;
      $display("FAIL abort count got=%0d exp=2", count);
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abort done_pulses got=%0d exp=0", done_cnt - d0);
    end
    check_bank("abort");
  endtask

  task automatic test_start_in_load();
    int d0 = done_cnt, c0 = clr_full_cnt;
    do_start(3);
    send(8'h11, 1'b0);
    start = 1'b1; len = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check_last("start_in_load", 32'h4);
    wait_idle();
    check_frame("start_in_load", 3, done_cnt - d0, clr_full_cnt - c0);
    check_bank("start_in_load");
  endtask

  task automatic test_len_edges();
    logic [CW-1:0] ls[2] = '{6'd0, 6'd40};
    int d0, c0;
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt; c0 = clr_full_cnt;
      do_start(ls[k]);
      for (int i = 0; i < 32; i++) send(DW'(8'hC0 + i), 1'b0);
      check_last("len_full", 32'h8000_0000);
      wait_idle();
      check_frame("len_full", 32, done_cnt - d0, clr_full_cnt - c0);
    end
    d0 = done_cnt; c0 = clr_full_cnt;
    do_start(1);
    send(8'h9E, 1'b0);
    check_last("len1", 32'h1);
    wait_idle();
    check_frame("len1", 1, done_cnt - d0, clr_full_cnt - c0);
    check_bank("len1");
  endtask

  task automatic test_rst_in_load();
    int d0, c0;
    do_start(8);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({en, clr, d, done, count, busy, s_ready} !== '0) begin
      errors++;
      $display("FAIL rst_in_load en=%h clr=%h d=%h done=%b cnt=%0d busy=%b rdy=%b exp all 0",
               en, clr, d, done, count, busy, s_ready);
    end
    @(posedge clk); #1;
    d0 = done_cnt; c0 = clr_full_cnt;
    do_start(2);
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    check_last("after_rst", 32'h2);
    wait_idle();
    check_frame("after_rst", 2, done_cnt - d0, clr_full_cnt - c0);
    check_bank("after_rst");
  endtask

  task automatic test_pad();
    int d0 = done_cnt, c0 = clr_full_cnt;
    do_start(8);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
`ifdef CONV_CTRL_ZERO_PAD_EN
    @(negedge clk);
    checks++;
    if (clr !== 32'h0000_00F8 || done !== 1'b0) begin
      errors++;
      $display("FAIL pad clr=%h done=%b exp 000000f8 0", clr, done);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || en !== '0 || clr !== '0) begin
      errors++;
      $display("FAIL pad_done done=%b en=%h clr=%h exp 1 0 0", done, en, clr);
    end
    @(posedge clk); #1;
    wait_idle();
    check_frame("pad", 3, done_cnt - d0, clr_full_cnt - c0);
`else
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL no_pad_wait busy=%b rdy=%b dones=%0d exp 1 1 0", busy, s_ready, done_cnt - d0);
    end
    @(posedge clk); #1;
    for (int i = 3; i < 8; i++) send(DW'(8'h40 + i), 1'b0);
    check_last("no_pad", 32'h80);
    wait_idle();
    check_frame("no_pad", 8, done_cnt - d0, clr_full_cnt - c0);
`endif
    check_bank("pad");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_toggle();
    test_abort();
    test_start_in_load();
    test_len_edges();
    test_rst_in_load();
    test_pad();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
